// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory port arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;
  typedef enum logic {OWN_F, OWN_D} owner_t;

  localparam int FETCH_BYTES = 10;
  localparam int DATA_BYTES  = 8;

  // Index of the final byte of a transfer for the given owner (N-1)
  function automatic logic [3:0] last_index(input owner_t owner);
    return (owner == OWN_F) ? 4'(FETCH_BYTES - 1) : 4'(DATA_BYTES - 1);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - fetch/data request ports and byte-wide RAM port bundle
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 10
);

  logic              f_req;
  logic [63:0]       f_addr;
  logic              f_done;
  logic [79:0]       f_data;
  logic              f_err;

  logic              d_req;
  logic              d_we;
  logic [63:0]       d_addr;
  logic [63:0]       d_wdata;
  logic              d_done;
  logic [63:0]       d_rdata;
  logic              d_err;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  logic              busy;

  // The requesting pipeline stages plus the RAM model sit on the master side
  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  f_done, f_data, f_err, d_done, d_rdata, d_err,
           mem_addr, mem_we, mem_wdata, busy
  );

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output f_done, f_data, f_err, d_done, d_rdata, d_err,
           mem_addr, mem_we, mem_wdata, busy
  );

endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - byte-serial sequencer sharing one data RAM between fetch and memory stages
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10
) (
  input logic               clk,
  input logic               reset,
  dmem_port_arbiter_if.slave bus
);

  state_t            state;
  state_t            state_n;
  owner_t            owner;
  logic              we_q;
  logic [63:0]       wdata_q;
  logic [ADDR_W-1:0] base_q;
  logic [3:0]        count;
  logic              err_q;
  logic              cap_valid;
  logic [3:0]        cap_lane;
  logic [79:0]       f_data_q;
  logic [63:0]       d_data_q;

  logic              req_any;
  owner_t            grant_owner;
  logic [63:0]       grant_base;
  logic [64:0]       grant_end;
  logic              grant_err;
  logic              last_byte;

  logic [ADDR_W-1:0] mem_addr_c;
  logic              mem_we_c;
  logic [7:0]        mem_wdata_c;
  logic              f_done_c;
  logic              f_err_c;
  logic              d_done_c;
  logic              d_err_c;

  // Data stage always wins; 65-bit end address catches 64-bit wrap-around
  assign req_any     = bus.d_req | bus.f_req;
  assign grant_owner = bus.d_req ? OWN_D : OWN_F;
  assign grant_base  = bus.d_req ? bus.d_addr : bus.f_addr;
  assign grant_end   = {1'b0, grant_base} + 65'(last_index(grant_owner));
  assign grant_err   = (grant_end >= 65'(MEM_BYTES));
  assign last_byte   = (count == last_index(owner));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    mem_addr_c  = '0;
    mem_we_c    = 1'b0;
    mem_wdata_c = 8'h00;
    f_done_c    = 1'b0;
    f_err_c     = 1'b0;
    d_done_c    = 1'b0;
    d_err_c     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_any) begin
          state_n = grant_err ? DONE : XFER;
        end
      end
      XFER: begin
        mem_addr_c = base_q + ADDR_W'(count);
        if (we_q) begin
          mem_we_c    = 1'b1;
          mem_wdata_c = wdata_q[{count[2:0], 3'b000} +: 8];
        end
        if (last_byte) begin
          state_n = we_q ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
        if (owner == OWN_D) begin
          d_done_c = 1'b1;
          d_err_c  = err_q;
        end else begin
          f_done_c = 1'b1;
          f_err_c  = err_q;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= OWN_F;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      base_q    <= '0;
      count     <= '0;
      err_q     <= 1'b0;
      cap_valid <= 1'b0;
      cap_lane  <= '0;
      f_data_q  <= '0;
      d_data_q  <= '0;
    end else begin
      // RAM read data lags the address by one cycle, so remember which lane it belongs to
      cap_valid <= (state == XFER) && !we_q;
      cap_lane  <= count;
      if (state == IDLE && req_any) begin
        owner   <= grant_owner;
        we_q    <= bus.d_req & bus.d_we;
        wdata_q <= bus.d_wdata;
        base_q  <= grant_base[ADDR_W-1:0];
        count   <= '0;
        err_q   <= grant_err;
      end else if (state == XFER) begin
        count <= count + 4'd1;
      end
      if (cap_valid) begin
        if (owner == OWN_D) begin
          d_data_q[{cap_lane[2:0], 3'b000} +: 8] <= bus.mem_rdata;
        end else begin
          f_data_q[{cap_lane, 3'b000} +: 8] <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.f_done    = f_done_c;
  assign bus.f_err     = f_err_c;
  assign bus.f_data    = f_data_q;
  assign bus.d_done    = d_done_c;
  assign bus.d_err     = d_err_c;
  assign bus.d_rdata   = d_data_q;
  assign bus.busy      = (state != IDLE);

endmodule
